dso_cmd_dispatch: RTL and testbench

Command decoder/dispatcher between the host-side UART wrapper and the rest of the DSO digital core. It accepts 24-bit host commands, updates the capture configuration registers, and issues 16-bit SPI transactions to the gain pots, trigger pot and calibration EEPROM. It returns a one-byte response (ACK, NAK or read data) to the UART wrapper. It also hands channel-dump requests to the dump engine.

---
 rtl/dso_cmd_pkg.sv | 41 ++++
 rtl/dso_cmd_dispatch.sv | 189 ++++++++++++++++++
 tb/tb_dso_cmd_dispatch.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dso_cmd_pkg.sv
// Shared constants and types for the DSO host command dispatcher.
// Holds opcodes, slave-select codes, pot/EEPROM constants and the FSM state type.
package dso_cmd_pkg;

   localparam logic [7:0] ACK          = 8'hA5;
   localparam logic [7:0] NAK          = 8'hEE;
   localparam logic [7:0] TRIG_LVL_MIN = 8'd46;
   localparam logic [7:0] TRIG_LVL_MAX = 8'd201;

   localparam logic [7:0] CMD_DUMP     = 8'h01;
   localparam logic [7:0] CMD_GAIN     = 8'h02;
   localparam logic [7:0] CMD_TRIG_LVL = 8'h03;
   localparam logic [7:0] CMD_TRIG_POS = 8'h04;
   localparam logic [7:0] CMD_DEC      = 8'h05;
   localparam logic [7:0] CMD_TRIG_CFG = 8'h06;
   localparam logic [7:0] CMD_CFG_RD   = 8'h07;
   localparam logic [7:0] CMD_EEP_WR   = 8'h08;
   localparam logic [7:0] CMD_EEP_RD   = 8'h09;

   localparam logic [2:0] SS_CH1  = 3'd0;
   localparam logic [2:0] SS_CH2  = 3'd1;
   localparam logic [2:0] SS_CH3  = 3'd2;
   localparam logic [2:0] SS_TRIG = 3'd3;
   localparam logic [2:0] SS_EEP  = 3'd4;

   localparam logic [7:0] POT_WR = 8'h13;

   // Digital-pot wiper codes for the eight front-end gain settings.
   localparam logic [7:0] GAIN_LUT [0:7] = '{8'h02, 8'h05, 8'h09, 8'h0E,
                                             8'h2B, 8'h48, 8'h9A, 8'hC6};

   typedef enum logic [2:0] {
      IDLE,
      DISPATCH,
      SPI_WAIT,
      DUMP_WAIT,
      RESP,
      RESP_WAIT
   } state_t;

endpackage

// File: rtl/dso_cmd_dispatch.sv
// Host command decoder: updates capture config registers, drives SPI writes to the
// gain/trigger pots and EEPROM, and returns a one-byte response to the UART wrapper.
module dso_cmd_dispatch
   import dso_cmd_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] cmd,
   input  logic        cmd_rdy,
   output logic        clr_cmd_rdy,
   output logic [7:0]  resp,
   output logic        send_resp,
   input  logic        resp_sent,
   output logic        wrt_SPI,
   output logic [15:0] SPI_data,
   output logic [2:0]  ss,
   input  logic        SPI_done,
   input  logic [15:0] SPI_rd_data,
   output logic [8:0]  trig_pos,
   output logic [3:0]  decimator,
   output logic [5:0]  trig_cfg,
   input  logic        set_capture_done,
   output logic        dump_req,
   output logic [1:0]  dump_ch,
   input  logic        dump_done
);

   state_t      state, state_d;
   logic [23:0] cmd_q, cmd_d;
   logic        clr_d, send_d, wrt_d, dump_req_d;
   logic [7:0]  resp_d;
   logic [15:0] spi_data_d;
   logic [2:0]  ss_d;
   logic [8:0]  trig_pos_d;
   logic [3:0]  dec_d;
   logic [5:0]  cfg_d;
   logic [1:0]  dump_ch_d;

   logic [7:0]  opcode;
   logic [1:0]  cc;
   logic [7:0]  lvl;

   assign opcode = cmd_q[23:16];
   assign cc     = cmd_q[9:8];
   assign lvl    = cmd_q[7:0];

   // Operand bits no command uses, and the MISO high byte which EEPROM reads discard.
   logic unused_bits;
   assign unused_bits = ^{cmd_q[15:14], SPI_rd_data[15:8]};

   always_comb begin
      // NOTE: every signal gets its hold/idle value first so no path leaves one unassigned (no latches).
      state_d    = state;
      cmd_d      = cmd_q;
      clr_d      = 1'b0;
      send_d     = 1'b0;
      wrt_d      = 1'b0;
      dump_req_d = 1'b0;
      resp_d     = resp;
      spi_data_d = SPI_data;
      ss_d       = ss;
      trig_pos_d = trig_pos;
      dec_d      = decimator;
      cfg_d      = trig_cfg;
      dump_ch_d  = dump_ch;

      case (state)
         IDLE: begin
            if (cmd_rdy) begin
               cmd_d   = cmd;
               clr_d   = 1'b1;
               state_d = DISPATCH;
            end
         end

         DISPATCH: begin
            state_d = RESP;
            resp_d  = ACK;
            case (opcode)
               CMD_DUMP: begin
                  if (cc == 2'd3) begin
                     resp_d = NAK;
                  end else begin
                     dump_ch_d  = cc;
                     dump_req_d = 1'b1;
                     state_d    = DUMP_WAIT;
                  end
               end
               CMD_GAIN: begin
                  if (cc == 2'd3) begin
                     resp_d = NAK;
                  end else begin
                     ss_d       = {1'b0, cc};
                     spi_data_d = {POT_WR, GAIN_LUT[cmd_q[12:10]]};
                     wrt_d      = 1'b1;
                     state_d    = SPI_WAIT;
                  end
               end
               CMD_TRIG_LVL: begin
                  if (lvl < TRIG_LVL_MIN || lvl > TRIG_LVL_MAX) begin
                     resp_d = NAK;
                  end else begin
                     ss_d       = SS_TRIG;
                     spi_data_d = {POT_WR, lvl};
                     wrt_d      = 1'b1;
                     state_d    = SPI_WAIT;
                  end
               end
               CMD_TRIG_POS: trig_pos_d = cmd_q[8:0];
               CMD_DEC:      dec_d      = cmd_q[3:0];
               CMD_TRIG_CFG: cfg_d      = cmd_q[5:0];
               CMD_CFG_RD:   resp_d     = {2'b00, trig_cfg};
               CMD_EEP_WR: begin
                  ss_d       = SS_EEP;
                  spi_data_d = {2'b01, cmd_q[13:8], cmd_q[7:0]};
                  wrt_d      = 1'b1;
                  state_d    = SPI_WAIT;
               end
               CMD_EEP_RD: begin
                  ss_d       = SS_EEP;
                  spi_data_d = {2'b00, cmd_q[13:8], 8'h00};
                  wrt_d      = 1'b1;
                  state_d    = SPI_WAIT;
               end
               default: resp_d = NAK;
            endcase
         end

         SPI_WAIT: begin
            if (SPI_done) begin
               resp_d  = (opcode == CMD_EEP_RD) ? SPI_rd_data[7:0] : ACK;
               state_d = RESP;
            end
         end

         DUMP_WAIT: begin
            if (dump_done) state_d = IDLE;
         end

         RESP: begin
            send_d  = 1'b1;
            state_d = RESP_WAIT;
         end

         RESP_WAIT: begin
            if (resp_sent) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // Capture-done is sticky and wins over a concurrent config write.
      if (set_capture_done) cfg_d[5] = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state       <= IDLE;
         cmd_q       <= '0;
         clr_cmd_rdy <= 1'b0;
         send_resp   <= 1'b0;
         wrt_SPI     <= 1'b0;
         dump_req    <= 1'b0;
         resp        <= '0;
         SPI_data    <= '0;
         ss          <= '0;
         trig_pos    <= 9'h001;
         decimator   <= '0;
         trig_cfg    <= '0;
         dump_ch     <= '0;
      end else begin
         state       <= state_d;
         cmd_q       <= cmd_d;
         clr_cmd_rdy <= clr_d;
         send_resp   <= send_d;
         wrt_SPI     <= wrt_d;
         dump_req    <= dump_req_d;
         resp        <= resp_d;
         SPI_data    <= spi_data_d;
         ss          <= ss_d;
         trig_pos    <= trig_pos_d;
         decimator   <= dec_d;
         trig_cfg    <= cfg_d;
         dump_ch     <= dump_ch_d;
      end
   end

endmodule

// File: tb/tb_dso_cmd_dispatch.sv
// Table-driven bench for dso_cmd_dispatch with a few hand-written sequences
// for capture-done collisions, stray handshakes and mid-transaction reset.
module tb_dso_cmd_dispatch;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  resp;
   logic        send_resp;
   logic        resp_sent;
   logic        wrt_SPI;
   logic [15:0] SPI_data;
   logic [2:0]  ss;
   logic        SPI_done;
   logic [15:0] SPI_rd_data;
   logic [8:0]  trig_pos;
   logic [3:0]  decimator;
   logic [5:0]  trig_cfg;
   logic        set_capture_done;
   logic        dump_req;
   logic [1:0]  dump_ch;
   logic        dump_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dso_cmd_dispatch dut (
      .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
      .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent),
      .wrt_SPI(wrt_SPI), .SPI_data(SPI_data), .ss(ss), .SPI_done(SPI_done),
      .SPI_rd_data(SPI_rd_data), .trig_pos(trig_pos), .decimator(decimator),
      .trig_cfg(trig_cfg), .set_capture_done(set_capture_done),
      .dump_req(dump_req), .dump_ch(dump_ch), .dump_done(dump_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [23:0] cmd;
      logic [15:0] rd;
      bit          cap;
      bit          exp_spi;
      logic [2:0]  exp_ss;
      logic [15:0] exp_data;
      bit          exp_dump;
      logic [1:0]  exp_dump_ch;
      bit          exp_resp;
      logic [7:0]  exp_rval;
      bit          chk_lat;
      logic [8:0]  exp_tp;
      logic [3:0]  exp_dec;
      logic [5:0]  exp_cfg;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [23:0] c, input logic [15:0] rd, input bit cap,
                               input bit sp, input logic [2:0] s, input logic [15:0] d,
                               input bit dm, input logic [1:0] dc,
                               input bit rv, input logic [7:0] r, input bit lat,
                               input logic [8:0] tp, input logic [3:0] dec, input logic [5:0] cfg);
      vec_t v;
      v.cmd = c; v.rd = rd; v.cap = cap; v.exp_spi = sp; v.exp_ss = s; v.exp_data = d;
      v.exp_dump = dm; v.exp_dump_ch = dc; v.exp_resp = rv; v.exp_rval = r; v.chk_lat = lat;
      v.exp_tp = tp; v.exp_dec = dec; v.exp_cfg = cfg;
      return v;
   endfunction

   // Drive one command and play the UART/SPI/dump peers until it completes.
   task automatic run_vec(input int idx, input vec_t v);
      bit got_spi = 0, got_resp = 0, got_dump = 0, stable = 1;
      int spi_cnt = -1, dump_cyc = 0, resp_cyc = 0;
      logic [2:0]  ss_cap = '0;
      logic [15:0] data_cap = '0;
      string tag = $sformatf("v%0d", idx);
      @(negedge clk);
      cmd = v.cmd; cmd_rdy = 1'b1; SPI_rd_data = v.rd; set_capture_done = v.cap;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         resp_sent = 1'b0; SPI_done = 1'b0; dump_done = 1'b0;
         if (clr_cmd_rdy) cmd_rdy = 1'b0;
         if (spi_cnt > 0 && (ss !== ss_cap || SPI_data !== data_cap)) stable = 0;
         if (wrt_SPI) begin
            got_spi = 1; ss_cap = ss; data_cap = SPI_data; spi_cnt = 3;
         end else if (spi_cnt > 0) begin
            spi_cnt--;
            if (spi_cnt == 0) SPI_done = 1'b1;
         end
         if (dump_req && !got_dump) begin
            got_dump = 1; dump_cyc = cyc; dump_done = 1'b1;
            check({tag, "_dump_ch"}, 32'(dump_ch), 32'(v.exp_dump_ch));
         end
         if (send_resp && !got_resp) begin
            got_resp = 1; resp_cyc = cyc; resp_sent = 1'b1;
            check({tag, "_resp"}, 32'(resp), 32'(v.exp_rval));
         end
         if (got_resp || (got_dump && cyc >= dump_cyc + 4)) break;
      end
      @(negedge clk);
      resp_sent = 1'b0; SPI_done = 1'b0; dump_done = 1'b0; set_capture_done = 1'b0;
      cmd_rdy = 1'b0;
      check({tag, "_spi_seen"}, 32'(got_spi), 32'(v.exp_spi));
      if (v.exp_spi) begin
         check({tag, "_ss"}, 32'(ss_cap), 32'(v.exp_ss));
         check({tag, "_spi_data"}, 32'(data_cap), 32'(v.exp_data));
         check({tag, "_spi_stable"}, 32'(stable), 32'd1);
      end
      check({tag, "_dump_seen"}, 32'(got_dump), 32'(v.exp_dump));
      check({tag, "_resp_seen"}, 32'(got_resp), 32'(v.exp_resp));
      // cmd_rdy sampled at the edge before the first negedge; send_resp is visible
      // after the second further edge, i.e. at the third negedge.
      if (v.chk_lat) check({tag, "_latency"}, 32'(resp_cyc), 32'd3);
      check({tag, "_trig_pos"}, 32'(trig_pos), 32'(v.exp_tp));
      check({tag, "_decimator"}, 32'(decimator), 32'(v.exp_dec));
      check({tag, "_trig_cfg"}, 32'(trig_cfg), 32'(v.exp_cfg));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_clr"},  32'(clr_cmd_rdy), 32'd0);
      check({tag, "_send"}, 32'(send_resp), 32'd0);
      check({tag, "_wrt"},  32'(wrt_SPI), 32'd0);
      check({tag, "_dreq"}, 32'(dump_req), 32'd0);
      check({tag, "_resp"}, 32'(resp), 32'd0);
      check({tag, "_data"}, 32'(SPI_data), 32'd0);
      check({tag, "_ss"},   32'(ss), 32'd0);
      check({tag, "_tpos"}, 32'(trig_pos), 32'h001);
      check({tag, "_dec"},  32'(decimator), 32'd0);
      check({tag, "_cfg"},  32'(trig_cfg), 32'd0);
      check({tag, "_dch"},  32'(dump_ch), 32'd0);
   endtask

   initial begin
      bit any_pulse;
      rst = 1'b1; cmd = '0; cmd_rdy = 1'b0; resp_sent = 1'b0; SPI_done = 1'b0;
      SPI_rd_data = '0; set_capture_done = 1'b0; dump_done = 1'b0;

      //         cmd          rd       cap spi ss   data      dmp dch rsp rval   lat tp      dec  cfg
      vecs.push_back(mk(24'h02_0800, 16'h0, 0, 1, 3'd0, 16'h1309, 0, 0, 1, 8'hA5, 0, 9'h001, 4'd0, 6'h00));
      vecs.push_back(mk(24'h02_1D01, 16'h0, 0, 1, 3'd1, 16'h13C6, 0, 0, 1, 8'hA5, 0, 9'h001, 4'd0, 6'h00));
      vecs.push_back(mk(24'h02_0B00, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'hEE, 1, 9'h001, 4'd0, 6'h00));
      vecs.push_back(mk(24'h03_0020, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'hEE, 1, 9'h001, 4'd0, 6'h00));
      vecs.push_back(mk(24'h03_002E, 16'h0, 0, 1, 3'd3, 16'h132E, 0, 0, 1, 8'hA5, 0, 9'h001, 4'd0, 6'h00));
      vecs.push_back(mk(24'h03_00C9, 16'h0, 0, 1, 3'd3, 16'h13C9, 0, 0, 1, 8'hA5, 0, 9'h001, 4'd0, 6'h00));
      vecs.push_back(mk(24'h03_00CA, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'hEE, 1, 9'h001, 4'd0, 6'h00));
      vecs.push_back(mk(24'h03_0080, 16'h0, 0, 1, 3'd3, 16'h1380, 0, 0, 1, 8'hA5, 0, 9'h001, 4'd0, 6'h00));
      vecs.push_back(mk(24'h04_0100, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'hA5, 1, 9'h100, 4'd0, 6'h00));
      vecs.push_back(mk(24'h05_0007, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'hA5, 1, 9'h100, 4'd7, 6'h00));
      vecs.push_back(mk(24'h06_0014, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'hA5, 1, 9'h100, 4'd7, 6'h14));
      vecs.push_back(mk(24'h07_0000, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'h34, 1, 9'h100, 4'd7, 6'h34));
      vecs.push_back(mk(24'h08_05C3, 16'h0, 0, 1, 3'd4, 16'h45C3, 0, 0, 1, 8'hA5, 0, 9'h100, 4'd7, 6'h34));
      vecs.push_back(mk(24'h09_0500, 16'h7EC3, 0, 1, 3'd4, 16'h0500, 0, 0, 1, 8'hC3, 0, 9'h100, 4'd7, 6'h34));
      vecs.push_back(mk(24'h0A_0000, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'hEE, 1, 9'h100, 4'd7, 6'h34));
      vecs.push_back(mk(24'h01_0200, 16'h0, 0, 0, 3'd0, 16'h0,    1, 2, 0, 8'h00, 0, 9'h100, 4'd7, 6'h34));
      vecs.push_back(mk(24'h01_0300, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'hEE, 1, 9'h100, 4'd7, 6'h34));
      vecs.push_back(mk(24'h00_0000, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'hEE, 1, 9'h100, 4'd7, 6'h34));
      vecs.push_back(mk(24'h06_0003, 16'h0, 1, 0, 3'd0, 16'h0,    0, 0, 1, 8'hA5, 1, 9'h100, 4'd7, 6'h23));
      vecs.push_back(mk(24'h06_0000, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'hA5, 1, 9'h100, 4'd7, 6'h00));
      vecs.push_back(mk(24'h06_0014, 16'h0, 0, 0, 3'd0, 16'h0,    0, 0, 1, 8'hA5, 1, 9'h100, 4'd7, 6'h14));

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         // Capture engine flags done between the config write and the config read.
         if (i == 11) begin
            @(negedge clk); set_capture_done = 1'b1;
            @(negedge clk); set_capture_done = 1'b0;
            check("capdone_set", 32'(trig_cfg), 32'h34);
         end
         run_vec(i, vecs[i]);
      end

      // Stray handshakes in IDLE must not start anything.
      any_pulse = 0;
      @(negedge clk); SPI_done = 1'b1; resp_sent = 1'b1; dump_done = 1'b1;
      @(negedge clk); SPI_done = 1'b0; resp_sent = 1'b0; dump_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (clr_cmd_rdy || send_resp || wrt_SPI || dump_req) any_pulse = 1;
         @(negedge clk);
      end
      check("stray_idle_pulses", 32'(any_pulse), 32'd0);

      // Reset while an EEPROM write waits on SPI_done.
      @(negedge clk); cmd = 24'h08_1234; cmd_rdy = 1'b1;
      begin
         bit seen = 0;
         for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (clr_cmd_rdy) cmd_rdy = 1'b0;
            if (wrt_SPI) seen = 1;
         end
         check("rst_mid_wrt_seen", 32'(seen), 32'd1);
      end
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      rst = 1'b0; SPI_done = 1'b1;
      @(negedge clk); SPI_done = 1'b0;
      any_pulse = 0;
      for (int k = 0; k < 6; k++) begin
         if (send_resp || wrt_SPI || clr_cmd_rdy) any_pulse = 1;
         @(negedge clk);
      end
      check("rst_mid_no_resp", 32'(any_pulse), 32'd0);

      run_vec(99, mk(24'h05_0003, 16'h0, 0, 0, 3'd0, 16'h0, 0, 0, 1, 8'hA5, 1, 9'h001, 4'd3, 6'h00));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
